// File: rtl/rld_pkg.sv
// rld_pkg: mode encodings, per-channel state encoding and RUN_LEN limits for run_length_detector.
package rld_pkg;
  localparam int RLD_MODE_BOTH = 0;
  localparam int RLD_MODE_ZERO = 1;
  localparam int RLD_MODE_ONE = 2;
  localparam int RLD_RUN_LEN_MIN = 2;
  localparam int RLD_RUN_LEN_MAX = 255;
  typedef enum logic [2:0] {
    EMPTY = 3'b001,
    RUN = 3'b010,
    DET = 3'b100
  } rld_state_t;
  function automatic logic mode_ok(input int mode, input logic v);
    return mode == RLD_MODE_BOTH || (mode == RLD_MODE_ZERO && !v) || (mode == RLD_MODE_ONE && v);
  endfunction
endpackage

// File: rtl/rld_channel.sv
// rld_channel: one channel's run counter, last-value register and detect/pulse flags.
// RUN_COUNT_OUT_EN exposes the saturated run count on cnt.
module rld_channel
  import rld_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int MODE = RLD_MODE_BOTH,
  parameter int CNT_W = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic w,
  input  logic valid,
  input  logic clr,
  output logic s,
  output logic z,
  output logic pulse
`ifdef RUN_COUNT_OUT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RUN_LEN);
  rld_state_t st, st_n;
  logic [CNT_W-1:0] count, count_n;
  logic last, last_n, s_n, pulse_n, restart;
  always_comb begin
    restart = st == EMPTY || w != last;
    last_n = clr ? 1'b0 : valid ? w : last;
    count_n = clr ? '0 : !valid ? count : restart ? CNT_W'(1) : count == FULL ? count : count + 1'b1;
    st_n = count_n == '0 ? EMPTY : count_n == FULL ? DET : RUN;
    s_n = clr ? 1'b0 : valid ? count_n == FULL && mode_ok(MODE, last_n) : s;
    pulse_n = s_n & ~s;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= EMPTY;
      count <= '0;
      last <= 1'b0;
      s <= 1'b0;
      pulse <= 1'b0;
    end else begin
      st <= st_n;
      count <= count_n;
      last <= last_n;
      s <= s_n;
      pulse <= pulse_n;
    end
  end
  // The run value register doubles as the z output: both load w on every valid sample.
  assign z = last;
`ifdef RUN_COUNT_OUT_EN
  assign cnt = count;
`endif
endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: per-channel detector of RUN_LEN equal consecutive valid samples.
// RUN_COUNT_OUT_EN adds the cnt port carrying each channel's saturated run length.
module run_length_detector
  import rld_pkg::*;
#(
  parameter int NCH = 1,
  parameter int RUN_LEN = 4,
  parameter int MODE = RLD_MODE_BOTH,
  parameter int CNT_W = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NCH-1:0] w,
  input  logic [NCH-1:0] valid,
  input  logic clr,
  output logic [NCH-1:0] s,
  output logic [NCH-1:0] z,
  output logic [NCH-1:0] pulse
`ifdef RUN_COUNT_OUT_EN
  ,
  output logic [NCH*CNT_W-1:0] cnt
`endif
);
  if (RUN_LEN < RLD_RUN_LEN_MIN || RUN_LEN > RLD_RUN_LEN_MAX || MODE < RLD_MODE_BOTH || MODE > RLD_MODE_ONE) begin : g_bad
    $error("run_length_detector: RUN_LEN or MODE out of range");
  end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rld_channel #(
      .RUN_LEN(RUN_LEN),
      .MODE(MODE),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .w(w[g]),
      .valid(valid[g]),
      .clr(clr),
      .s(s[g]),
      .z(z[g]),
      .pulse(pulse[g])
`ifdef RUN_COUNT_OUT_EN
      ,
      .cnt(cnt[g*CNT_W+:CNT_W])
`endif
    );
  end
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: four detector builds (three modes, RUN_LEN 4 and 255) on shared inputs,
// checked against a history-queue model of the run rules.
module tb_run_length_detector;
  logic clk = 0, rst = 1, clr = 0;
  logic [3:0] w = 0, valid = 0;
  logic [3:0] s0, z0, p0, s1, z1, p1, s2, z2, p2;
  logic s3, z3, p3;
`ifdef RUN_COUNT_OUT_EN
  logic [11:0] c0, c1, c2;
  logic [7:0] c3;
`endif
  run_length_detector #(.NCH(4), .RUN_LEN(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .w(w), .valid(valid), .clr(clr), .s(s0), .z(z0), .pulse(p0)
`ifdef RUN_COUNT_OUT_EN
    , .cnt(c0)
`endif
  );
  run_length_detector #(.NCH(4), .RUN_LEN(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .w(w), .valid(valid), .clr(clr), .s(s1), .z(z1), .pulse(p1)
`ifdef RUN_COUNT_OUT_EN
    , .cnt(c1)
`endif
  );
  run_length_detector #(.NCH(4), .RUN_LEN(4), .MODE(2)) u2 (
    .clk(clk), .rst(rst), .w(w), .valid(valid), .clr(clr), .s(s2), .z(z2), .pulse(p2)
`ifdef RUN_COUNT_OUT_EN
    , .cnt(c2)
`endif
  );
  run_length_detector #(.NCH(1), .RUN_LEN(255), .MODE(0)) u3 (
    .clk(clk), .rst(rst), .w(w[0]), .valid(valid[0]), .clr(clr), .s(s3), .z(z3), .pulse(p3)
`ifdef RUN_COUNT_OUT_EN
    , .cnt(c3)
`endif
  );
  always #5 clk = ~clk;
  wire [15:0] os_all = {3'b0, s3, s2, s1, s0};
  wire [15:0] oz_all = {3'b0, z3, z2, z1, z0};
  wire [15:0] op_all = {3'b0, p3, p2, p1, p0};
  int checks = 0, errors = 0;
  bit hist[4][$];
  int rl[4] = '{4, 4, 4, 255};
  int md[4] = '{0, 1, 2, 0};
  logic [3:0] es[4] = '{default: '0};
  logic [3:0] ez[4] = '{default: '0};
  logic [3:0] ep[4] = '{default: '0};
  int ec[4][4] = '{default: '{default: 0}};
  logic [3:0] wc = 0;

  function automatic int trail(int ch);
    int n = 0;
    for (int i = hist[ch].size() - 1; i >= 0; i--) begin
      if (hist[ch][i] != hist[ch][hist[ch].size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic compute();
    for (int d = 0; d < 4; d++) begin
      logic [3:0] ns = '0;
      for (int ch = 0; ch < 4; ch++) begin
        int r = trail(ch);
        bit lv = hist[ch].size() > 0 ? hist[ch][$] : 1'b0;
        bit ok = md[d] == 0 || (md[d] == 1 && !lv) || (md[d] == 2 && lv);
        ns[ch] = r >= rl[d] && ok;
        ez[d][ch] = lv;
        ec[d][ch] = r < rl[d] ? r : rl[d];
      end
      ep[d] = ns & ~es[d];
      es[d] = ns;
    end
  endtask

  task automatic model(input logic [3:0] wv, input logic [3:0] vv, input logic c);
    for (int ch = 0; ch < 4; ch++) begin
      if (c) hist[ch].delete();
      else if (vv[ch]) begin
        hist[ch].push_back(wv[ch]);
        if (hist[ch].size() > 260) void'(hist[ch].pop_front());
      end
    end
    compute();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

`ifdef RUN_COUNT_OUT_EN
  function automatic logic [31:0] cnt_of(int d, int ch);
    return d == 0 ? 32'(c0[ch*3+:3]) : d == 1 ? 32'(c1[ch*3+:3]) : d == 2 ? 32'(c2[ch*3+:3]) : 32'(c3);
  endfunction
`endif

  task automatic check_all();
    for (int d = 0; d < 4; d++) begin
      logic [3:0] m = d == 3 ? 4'h1 : 4'hF;
      check($sformatf("s u%0d", d), 32'(os_all[d*4+:4]), 32'(es[d] & m));
      check($sformatf("z u%0d", d), 32'(oz_all[d*4+:4]), 32'(ez[d] & m));
      check($sformatf("pulse u%0d", d), 32'(op_all[d*4+:4]), 32'(ep[d] & m));
`ifdef RUN_COUNT_OUT_EN
      for (int ch = 0; ch < (d == 3 ? 1 : 4); ch++)
        check($sformatf("cnt u%0d ch%0d", d, ch), cnt_of(d, ch), 32'(ec[d][ch]));
`endif
    end
  endtask

  task automatic step(input logic [3:0] wv, input logic [3:0] vv, input logic c);
    w = wv;
    valid = vv;
    clr = c;
    @(posedge clk);
    model(wv, vv, c);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1;
    for (int ch = 0; ch < 4; ch++) hist[ch].delete();
    compute();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 0;
    repeat (4) step(4'h0, 4'hF, 0);
    step(4'hF, 4'hF, 0);
    repeat (3) step(4'hF, 4'hF, 0);
    step(4'h0, 4'hF, 1);
    repeat (6) step(4'h0, 4'hF, 0);
    repeat (4) step(4'hF, 4'hF, 0);
    step(4'h0, 4'hF, 1);
    repeat (2) step(4'h0, 4'hF, 0);
    repeat (5) step(4'($urandom), 4'h0, 0);
    repeat (2) step(4'h0, 4'hF, 0);
    step(4'h0, 4'hF, 1);
    repeat (3) step(4'hA, 4'hF, 0);
    async_reset();
    repeat (4) step(4'hA, 4'hF, 0);
    for (int k = 0; k < 8; k++) step(k % 2 ? 4'hF : 4'h4, 4'hF, 0);
    step(4'h4, 4'hF, 1);
    step(4'h4, 4'h0, 0);
    repeat (300) step(4'hF, 4'hF, 0);
    step(4'h0, 4'h1, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) wc = 4'($urandom);
      wc ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(wc, ~(4'($urandom) & 4'($urandom)), $urandom_range(0, 99) == 0);
      if (i % 250 == 249) async_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
